// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// Holds the data width, the NOP encoding used to clear IF/ID, the fetch FSM
// state type, the per-cycle fetch decision type and the default reset PC.
// No ports; import with "import cpu_pkg::*;".
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } if_state_t;

  // What the fetch stage does with its registers on the coming edge.
  typedef enum logic [2:0] {
    P_IDLE,
    P_REDIRECT,
    P_FAULT,
    P_FLUSH,
    P_STALL,
    P_BUBBLE,
    P_ADVANCE
  } fetch_path_t;

  // Sequential next PC; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports:
//   clk   - clock, counts on rising edge
//   rst   - synchronous reset to zero
//   en    - increment enable
//   count - current value; sticks at all-ones
module sat_counter
  import cpu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// FSM BOOT -> RUN -> HALT; a misaligned redirect halts fetching until reset.
// Optional performance counters are built only when the macro IF_PERF_CNT_EN
// is defined; otherwise both counter ports read as zero.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   stall, flush                  - hold everything / squash IF/ID
//   redirect_valid, redirect_pc   - branch/jump target load
//   imem_req, imem_addr           - instruction memory request (addr = PC)
//   imem_ready, imem_rdata        - same-cycle instruction return
//   ifid_valid/pc/pc_plus4/instr  - IF/ID register
//   fetch_fault                   - sticky misaligned-redirect flag
//   perf_stall_cnt, perf_bubble_cnt - saturating stall/bubble counters
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            fetch_fault,
  output logic [XLEN-1:0] perf_stall_cnt,
  output logic [XLEN-1:0] perf_bubble_cnt
);

  if_state_t       state_q, state_d;
  fetch_path_t     path;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4  = pc_next(pc_q);
  assign imem_addr = pc_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, request and the per-cycle fetch decision. Control inputs are
  // only looked at in RUN, in priority redirect > flush > stall > not-ready.
  always_comb begin
    state_d  = state_q;
    path     = P_IDLE;
    imem_req = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          if (redirect_pc[1:0] == 2'b00) begin
            path = P_REDIRECT;
          end else begin
            path    = P_FAULT;
            state_d = HALT;
          end
        end else if (flush) begin
          path = P_FLUSH;
        end else if (stall) begin
          path = P_STALL;
        end else if (!imem_ready) begin
          path = P_BUBBLE;
        end else begin
          path = P_ADVANCE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // PC and IF/ID register. Flush and bubble only drop the valid bit so the
  // remaining IF/ID fields keep their last contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      ifid_instr    <= INSTR_NOP;
      fetch_fault   <= 1'b0;
    end else begin
      case (path)
        P_REDIRECT: begin
          pc_q       <= redirect_pc;
          ifid_valid <= 1'b0;
        end
        P_FAULT: begin
          ifid_valid  <= 1'b0;
          fetch_fault <= 1'b1;
        end
        P_FLUSH, P_BUBBLE: ifid_valid <= 1'b0;
        P_ADVANCE: begin
          ifid_valid    <= 1'b1;
          ifid_pc       <= pc_q;
          ifid_pc_plus4 <= pc_plus4;
          ifid_instr    <= imem_rdata;
          pc_q          <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  sat_counter #(.WIDTH(XLEN)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (path == P_STALL),
    .count (perf_stall_cnt)
  );

  sat_counter #(.WIDTH(XLEN)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (path == P_BUBBLE),
    .count (perf_bubble_cnt)
  );
`else
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage (RESET_PC = 0x40).
// A behavioural model tracks the fetch stage at the level of "what the
// pipeline should hold" and every cycle's outputs are compared against it,
// plus directed constant checks for the key scenarios.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, ifid_valid, fetch_fault;
  logic [31:0] imem_addr, ifid_pc, ifid_pc_plus4, ifid_instr;
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;

  int checks = 0;
  int passed = 0;

  // Reference model state.
  bit          m_booting, m_halted, m_valid, m_fault;
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
  logic [31:0] m_stalls, m_bubbles;

  localparam logic [31:0] RPC = 32'h0000_0040;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .ifid_valid      (ifid_valid),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_instr      (ifid_instr),
    .fetch_fault     (fetch_fault),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_exp(input logic [31:0] m);
`ifdef IF_PERF_CNT_EN
    return m;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, advance the model by the stage's rules,
  // and let the clock edge happen; returns 1 time unit after the edge.
  task automatic applyStimulus(input bit r, input bit s, input bit f, input bit rv,
                               input logic [31:0] rp, input bit rdy, input logic [31:0] rd);
    @(negedge clk);
    rst = r; stall = s; flush = f; redirect_valid = rv;
    redirect_pc = rp; imem_ready = rdy; imem_rdata = rd;
    if (r) begin
      m_booting = 1; m_halted = 0; m_valid = 0; m_fault = 0;
      m_pc = RPC; m_ifpc = 0; m_ifpc4 = 0; m_instr = 0;
      m_stalls = 0; m_bubbles = 0;
    end else if (m_booting) begin
      m_booting = 0;
    end else if (!m_halted) begin
      if (rv) begin
        m_valid = 0;
        if (rp % 4 == 0) m_pc = rp;
        else begin m_fault = 1; m_halted = 1; end
      end else if (f) begin
        m_valid = 0;
      end else if (s) begin
        if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      end else if (!rdy) begin
        m_valid = 0;
        if (m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 1;
      end else begin
        m_valid = 1; m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_instr = rd;
        m_pc = m_pc + 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".req"},    32'(imem_req),    32'(!m_booting && !m_halted));
    chk({tag, ".addr"},   imem_addr,        m_pc);
    chk({tag, ".valid"},  32'(ifid_valid),  32'(m_valid));
    chk({tag, ".pc"},     ifid_pc,          m_ifpc);
    chk({tag, ".pc4"},    ifid_pc_plus4,    m_ifpc4);
    chk({tag, ".instr"},  ifid_instr,       m_instr);
    chk({tag, ".fault"},  32'(fetch_fault), 32'(m_fault));
    chk({tag, ".stalls"}, perf_stall_cnt,   cnt_exp(m_stalls));
    chk({tag, ".bubbles"},perf_bubble_cnt,  cnt_exp(m_bubbles));
  endtask

  task automatic step(input string tag, input bit r, input bit s, input bit f, input bit rv,
                      input logic [31:0] rp, input bit rdy, input logic [31:0] rd);
    applyStimulus(r, s, f, rv, rp, rdy, rd);
    checkOutput(tag);
  endtask

  initial begin
    logic [31:0] rp;
    rst = 1; stall = 0; flush = 0; redirect_valid = 0;
    redirect_pc = 0; imem_ready = 1; imem_rdata = 0;

    // Reset, including with other inputs active.
    step("rst0", 1, 1, 1, 1, 32'h200, 1, 32'hDEAD_BEEF);
    step("rst1", 1, 0, 0, 0, 0, 1, 0);
    chk("rst.addr_const", imem_addr, 32'h40);
    chk("rst.req_const", 32'(imem_req), 0);

    // Boot then sequential fetch of A, B, C.
    step("boot", 0, 1, 1, 0, 0, 1, 0);
    chk("boot.req_const", 32'(imem_req), 1);
    step("fetchA", 0, 0, 0, 0, 0, 1, 32'hAAAA_0001);
    chk("fetchA.pc_const", ifid_pc, 32'h40);
    step("fetchB", 0, 0, 0, 0, 0, 1, 32'hBBBB_0002);
    chk("fetchB.pc_const", ifid_pc, 32'h44);
    step("fetchC", 0, 0, 0, 0, 0, 1, 32'hCCCC_0003);
    chk("fetchC.pc_const", ifid_pc, 32'h48);
    chk("fetchC.instr_const", ifid_instr, 32'hCCCC_0003);

    // Three stall cycles freeze everything.
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 0, 0, 1, $urandom);
    chk("stall.pc_const", ifid_pc, 32'h48);
    chk("stall.addr_const", imem_addr, 32'h4C);
    chk("stall.cnt_const", perf_stall_cnt, cnt_exp(32'd3));

    // Redirect wins over stall.
    step("redir", 0, 1, 1, 1, 32'h100, 1, $urandom);
    chk("redir.valid_const", 32'(ifid_valid), 0);
    step("redir2", 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    chk("redir2.pc_const", ifid_pc, 32'h100);

    // Flush keeps the other IF/ID fields.
    step("flush", 0, 1, 1, 0, 0, 1, $urandom);

    // Randomized traffic with occasional resets and misaligned redirects.
    for (int i = 0; i < 300; i++) begin
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      step("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), rp,
           ($urandom_range(0, 3) != 0), $urandom);
    end

    // PC wrap and bubbles, from a fresh reset.
    step("wrst", 1, 0, 0, 0, 0, 1, 0);
    step("wboot", 0, 0, 0, 0, 0, 1, 0);
    step("wredir", 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    step("wadv", 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
    chk("wrap.pc4_const", ifid_pc_plus4, 32'h0);
    chk("wrap.addr_const", imem_addr, 32'h0);
    chk("wrap.fault_const", 32'(fetch_fault), 0);
    step("bub1", 0, 0, 0, 0, 0, 0, $urandom);
    step("bub2", 0, 0, 0, 0, 0, 0, $urandom);
    chk("bub.cnt_const", perf_bubble_cnt, cnt_exp(32'd2));
    chk("bub.addr_const", imem_addr, 32'h0);

    // Misaligned redirect halts until reset.
    step("mis", 0, 0, 0, 1, 32'h0000_0102, 1, 0);
    chk("mis.fault_const", 32'(fetch_fault), 1);
    for (int i = 0; i < 4; i++) step("halt", 0, 0, 0, 1, 32'h200, 1, $urandom);
    chk("halt.req_const", 32'(imem_req), 0);
    chk("halt.valid_const", 32'(ifid_valid), 0);
    step("hrst", 1, 0, 0, 0, 0, 1, 0);
    chk("hrst.fault_const", 32'(fetch_fault), 0);
    chk("hrst.addr_const", imem_addr, 32'h40);
    step("hboot", 0, 0, 0, 0, 0, 1, 0);
    step("hfetch", 0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
    chk("hfetch.pc_const", ifid_pc, 32'h40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall  in  1  hold PC and IF/ID register (decode not accepting).
REQ-005 SHALL have port flush  in  1  squash IF/ID contents and hold PC.
REQ-006 SHALL have ports redirect_valid  in  1 and redirect_pc  in  32  branch/jump target load.
REQ-007 SHALL have ports imem_req  out  1 and imem_addr  out  32  instruction memory request.
REQ-008 SHALL have ports imem_ready  in  1 and imem_rdata  in  32  memory data valid in the same cycle.
REQ-009 SHALL have ports ifid_valid  out  1, ifid_pc  out  32, ifid_pc_plus4  out  32, ifid_instr  out  32  IF/ID register.
REQ-010 SHALL have port fetch_fault  out  1  sticky misaligned-redirect flag.
REQ-011 SHALL have ports perf_stall_cnt  out  32 and perf_bubble_cnt  out  32  performance counters.

Function
REQ-012 SHALL implement states BOOT, RUN, HALT; rst forces BOOT; BOOT->RUN unconditionally after one cycle; RUN->HALT on misaligned redirect; HALT exits only by rst.
REQ-013 SHALL drive imem_addr = pc_q always and imem_req = 1 only in RUN.
REQ-014 SHALL, in RUN with priority redirect > flush > stall > not-ready > advance, update per REQ-015..019.
REQ-015 Redirect (redirect_pc[1:0]==0): pc_q <= redirect_pc, ifid_valid <= 0; applies even when stall or flush is high.
REQ-016 Redirect with redirect_pc[1:0]!=0: pc_q unchanged, ifid_valid <= 0, fetch_fault <= 1, state <= HALT.
REQ-017 Flush without redirect: ifid_valid <= 0, pc_q held; other IF/ID fields unchanged.
REQ-018 Stall without redirect/flush: pc_q and all IF/ID fields held.
REQ-019 imem_ready=0 without redirect/flush/stall: pc_q held, ifid_valid <= 0 (bubble).
REQ-020 Advance (imem_ready=1, no stall/flush/redirect): ifid_valid <= 1, ifid_pc <= pc_q, ifid_pc_plus4 <= pc_q+4, ifid_instr <= imem_rdata, pc_q <= pc_q+4; fetch-to-IF/ID latency is one cycle.
REQ-021 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 without fault.
REQ-022 In BOOT and HALT, ifid_valid SHALL be 0 and stall/flush/redirect inputs ignored.

Reset
REQ-023 On rst at a rising edge, including mid-operation: state=BOOT, pc_q=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=INSTR_NOP (32'h0000_0000), fetch_fault=0, both counters=0.
REQ-024 rst SHALL override every other input in the same cycle.

Configuration
REQ-025 Macro IF_PERF_CNT_EN defined: perf_stall_cnt increments each RUN cycle taking the REQ-018 path; perf_bubble_cnt each RUN cycle taking the REQ-019 path; both saturate at 32'hFFFF_FFFF.
REQ-026 Macro IF_PERF_CNT_EN undefined: both counter ports present and tied to 0, no counter registers instantiated.

Structure
REQ-027 Shared package cpu_pkg SHALL hold XLEN=32, INSTR_NOP, the if_state typedef (BOOT/RUN/HALT), and the RESET_PC default constant.
REQ-028 Sub-module sat_counter (32-bit, enable input, saturating, sync reset) SHALL be instantiated twice, only under IF_PERF_CNT_EN.

Verification
REQ-029 Reset with RESET_PC=32'h0000_0040, imem_ready=1, rdata=A,B,C -> cycle 1 BOOT no req; then ifid (pc,instr) = (40,A),(44,B),(48,C), ifid_valid=1.
REQ-030 stall high 3 cycles during RUN -> pc_q and IF/ID frozen 3 cycles; perf_stall_cnt=3 with macro, 0 without.
REQ-031 redirect_valid with stall=1, redirect_pc=32'h0000_0100 -> next cycle ifid_valid=0, following cycle ifid_pc=32'h100.
REQ-032 redirect_pc=32'h0000_0102 -> fetch_fault=1, imem_req=0, ifid_valid=0 until rst; rst clears fault and restarts at RESET_PC.
REQ-033 pc_q=32'hFFFF_FFFC, advance -> ifid_pc_plus4=0, next fetch addr 0; imem_ready=0 for 2 cycles -> 2 bubbles, perf_bubble_cnt=2.
